phy_lane_scheduler: RTL and testbench

Transmit-side lane scheduler for the PHY. It shares a single byte slot stream to the serializer among four 8-bit input lanes (in0..in3 with valid_in0..valid_in3) using round-robin arbitration. After reset it runs a sync phase of IDLE characters, then grants one lane per byte slot. When no lane is valid it inserts IDLE. Sits between the lane sources and the parallel-to-serial stage, all on clk_32f.

---
 rtl/phy_lane_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_phy_lane_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/phy_lane_scheduler.sv
// Transmit-side lane scheduler: round-robin grants of four byte lanes onto one slot stream.
// Optional per-lane grant / idle statistics counters are enabled by defining PHY_SCHED_STATS_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | held in reset; slot counter frozen at 0
// ST_SYNC   | send SYNC_SLOTS IDLE slots, ignore requests
// ST_ACTIVE | grant one valid lane per slot, IDLE when none requests
module phy_lane_scheduler #(
    parameter int unsigned SLOT_CYCLES = 8,
    parameter int unsigned SYNC_SLOTS  = 4,
    parameter logic [7:0]  IDLE_CHAR   = 8'hBC,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic [7:0]       in0,
    input  logic [7:0]       in1,
    input  logic [7:0]       in2,
    input  logic [7:0]       in3,
    input  logic             valid_in0,
    input  logic             valid_in1,
    input  logic             valid_in2,
    input  logic             valid_in3,
    output logic             ready0,
    output logic             ready1,
    output logic             ready2,
    output logic             ready3,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic [1:0]       lane_id,
    output logic             sync_done
`ifdef PHY_SCHED_STATS_EN
   ,output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic [CNT_W-1:0] gnt_cnt2,
    output logic [CNT_W-1:0] gnt_cnt3,
    output logic [CNT_W-1:0] idle_cnt
`endif
);

    localparam int unsigned SLOT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned SYNC_W = (SYNC_SLOTS > 1) ? $clog2(SYNC_SLOTS + 1) : 1;

    typedef enum logic [1:0] {ST_RESET, ST_SYNC, ST_ACTIVE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [SYNC_W-1:0]   r_sync_cnt;
    logic [1:0]          r_rr_last;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_strobe;
    logic [1:0]          r_lane;
    logic                r_sync_done;

    logic                w_boundary;
    logic                w_sync_last;
    logic [3:0]          w_req;
    logic                w_found;
    logic [1:0]          w_gnt;
    logic [1:0]          w_idx;
    logic [7:0]          w_gnt_data;
    logic [3:0]          w_ready;

    assign w_req       = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign w_boundary  = (r_state != ST_RESET) && (r_slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
    assign w_sync_last = (r_sync_cnt == SYNC_W'(SYNC_SLOTS - 1));

    // Round-robin search starting just after the last granted lane.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_rr_last;
        w_idx   = r_rr_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_rr_last + 2'(k);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        case (w_gnt)
            2'd0:    w_gnt_data = in0;
            2'd1:    w_gnt_data = in1;
            2'd2:    w_gnt_data = in2;
            default: w_gnt_data = in3;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) r_state <= ST_RESET;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_SYNC;
            ST_SYNC:   if (w_boundary && w_sync_last) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: w_state_nxt = ST_ACTIVE;
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        w_ready = 4'b0000;
        if ((r_state == ST_ACTIVE) && w_boundary && w_found) w_ready[w_gnt] = 1'b1;
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_slot_cnt  <= '0;
            r_sync_cnt  <= '0;
            r_rr_last   <= 2'd3;
            r_data      <= IDLE_CHAR;
            r_valid     <= 1'b0;
            r_strobe    <= 1'b0;
            r_lane      <= 2'd0;
            r_sync_done <= 1'b0;
        end else begin
            if (r_state != ST_RESET)
                r_slot_cnt <= w_boundary ? '0 : r_slot_cnt + SLOT_W'(1);
            r_strobe    <= w_boundary;
            r_sync_done <= (w_state_nxt == ST_ACTIVE);
            if (w_boundary) begin
                if ((r_state == ST_ACTIVE) && w_found) begin
                    r_data    <= w_gnt_data;
                    r_valid   <= 1'b1;
                    r_lane    <= w_gnt;
                    r_rr_last <= w_gnt;
                end else begin
                    r_data  <= IDLE_CHAR;
                    r_valid <= 1'b0;
                end
                if (r_state == ST_SYNC) r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
            end
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign lane_id     = r_lane;
    assign sync_done   = r_sync_done;
    assign ready0      = w_ready[0];
    assign ready1      = w_ready[1];
    assign ready2      = w_ready[2];
    assign ready3      = w_ready[3];

`ifdef PHY_SCHED_STATS_EN
    logic [CNT_W-1:0] r_gnt_cnt [4];
    logic [CNT_W-1:0] r_idle_cnt;

    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) r_gnt_cnt[i] <= '0;
            r_idle_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_ready[i] && (r_gnt_cnt[i] != {CNT_W{1'b1}}))
                    r_gnt_cnt[i] <= r_gnt_cnt[i] + CNT_W'(1);
            if ((r_state == ST_ACTIVE) && w_boundary && !w_found && (r_idle_cnt != {CNT_W{1'b1}}))
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

    assign gnt_cnt0 = r_gnt_cnt[0];
    assign gnt_cnt1 = r_gnt_cnt[1];
    assign gnt_cnt2 = r_gnt_cnt[2];
    assign gnt_cnt3 = r_gnt_cnt[3];
    assign idle_cnt = r_idle_cnt;
`endif

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Directed bench for phy_lane_scheduler: sync phase, round-robin vectors, mid-slot reset, optional stats.
module tb_phy_lane_scheduler;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00, in3 = 8'h00;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
    logic       ready0, ready1, ready2, ready3;
    logic [7:0] data_out;
    logic       valid_out, byte_strobe, sync_done;
    logic [1:0] lane_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_32f = ~clk_32f;

`ifdef PHY_SCHED_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, gnt_cnt2, gnt_cnt3, idle_cnt;
    logic [1:0]  s_gnt0, s_gnt1, s_gnt2, s_gnt3, s_idle;
    logic        s_rdy0, s_rdy1, s_rdy2, s_rdy3, s_vout, s_strb, s_sync;
    logic [7:0]  s_data;
    logic [1:0]  s_lane;

    phy_lane_scheduler #(.CNT_W(2)) u_dut_sat (
        .clk_32f(clk_32f), .reset_L(reset_L),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
        .ready0(s_rdy0), .ready1(s_rdy1), .ready2(s_rdy2), .ready3(s_rdy3),
        .data_out(s_data), .valid_out(s_vout), .byte_strobe(s_strb), .lane_id(s_lane),
        .sync_done(s_sync),
        .gnt_cnt0(s_gnt0), .gnt_cnt1(s_gnt1), .gnt_cnt2(s_gnt2), .gnt_cnt3(s_gnt3),
        .idle_cnt(s_idle)
    );
`endif

    phy_lane_scheduler u_dut (
        .clk_32f(clk_32f), .reset_L(reset_L),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
        .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
        .data_out(data_out), .valid_out(valid_out), .byte_strobe(byte_strobe),
        .lane_id(lane_id), .sync_done(sync_done)
`ifdef PHY_SCHED_STATS_EN
       ,.gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .gnt_cnt2(gnt_cnt2), .gnt_cnt3(gnt_cnt3),
        .idle_cnt(idle_cnt)
`endif
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] d0, d1, d2, d3;
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic [1:0] exp_lane;
    } vec_t;

    vec_t vecs [16];

    // {ready3..0, byte_strobe, data_out, valid_out, lane_id, sync_done}
    function automatic logic [16:0] obs();
        return {ready3, ready2, ready1, ready0, byte_strobe, data_out, valid_out, lane_id, sync_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        {valid_in3, valid_in2, valid_in1, valid_in0} = v.valid;
        in0 = v.d0; in1 = v.d1; in2 = v.d2; in3 = v.d3;
    endtask

    // Called right after reset_L is released following a negedge; ends on the
    // negedge one cycle before the first ACTIVE boundary.
    task automatic run_sync();
        for (int n = 1; n <= 39; n++) begin
            @(negedge clk_32f);
            chk($sformatf("sync_n%0d", n), 32'(obs()),
                32'({4'b0000, ((n % 8 == 1) && (n >= 9)), 8'hBC, 1'b0, 2'd0, (n >= 33)}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p_data;
        logic       p_valid;
        logic [1:0] p_lane;

        vecs[0]  = '{4'b0010, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0010, 8'hBB, 1'b1, 2'd1};
        vecs[1]  = '{4'b0010, 8'hAA, 8'h3C, 8'hCC, 8'hDD, 4'b0010, 8'h3C, 1'b1, 2'd1};
        vecs[2]  = '{4'b0010, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0010, 8'hBB, 1'b1, 2'd1};
        vecs[3]  = '{4'b1000, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b1000, 8'hDD, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0001, 8'hAA, 1'b1, 2'd0};
        vecs[5]  = '{4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0010, 8'hBB, 1'b1, 2'd1};
        vecs[6]  = '{4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0100, 8'hCC, 1'b1, 2'd2};
        vecs[7]  = '{4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b1000, 8'hDD, 1'b1, 2'd3};
        vecs[8]  = '{4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0001, 8'hAA, 1'b1, 2'd0};
        vecs[9]  = '{4'b0101, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0100, 8'hCC, 1'b1, 2'd2};
        vecs[10] = '{4'b0000, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0000, 8'hBC, 1'b0, 2'd2};
        vecs[11] = '{4'b0101, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0001, 8'hAA, 1'b1, 2'd0};
        vecs[12] = '{4'b0101, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0100, 8'hCC, 1'b1, 2'd2};
        vecs[13] = '{4'b1011, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b1000, 8'hDD, 1'b1, 2'd3};
        vecs[14] = '{4'b1011, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0001, 8'hAA, 1'b1, 2'd0};
        vecs[15] = '{4'b1011, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0010, 8'hBB, 1'b1, 2'd1};

        @(negedge clk_32f);
        chk("reset_values", 32'(obs()), 32'({4'b0000, 1'b0, 8'hBC, 1'b0, 2'd0, 1'b0}));
        @(negedge clk_32f);
        #1 reset_L = 1'b1;
        run_sync();

        p_data = 8'hBC; p_valid = 1'b0; p_lane = 2'd0;
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            @(negedge clk_32f);
            chk($sformatf("v%0d_boundary", i), 32'(obs()),
                32'({vecs[i].exp_ready, 1'b0, p_data, p_valid, p_lane, 1'b1}));
            @(negedge clk_32f);
            chk($sformatf("v%0d_present", i), 32'(obs()),
                32'({4'b0000, 1'b1, vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_lane, 1'b1}));
            repeat (5) @(negedge clk_32f);
            chk($sformatf("v%0d_hold", i), 32'(obs()),
                32'({4'b0000, 1'b0, vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_lane, 1'b1}));
            @(negedge clk_32f);
            p_data = vecs[i].exp_data; p_valid = vecs[i].exp_valid; p_lane = vecs[i].exp_lane;
        end

        // Mid-slot reset while lane 0 carries 8'hFF; rr pointer was last on lane 1.
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0001;
        in0 = 8'hFF;
        @(negedge clk_32f);
        chk("rst_seq_boundary", 32'(obs()), 32'({4'b0001, 1'b0, 8'hBB, 1'b1, 2'd1, 1'b1}));
        @(negedge clk_32f);
        chk("rst_seq_present", 32'(obs()), 32'({4'b0000, 1'b1, 8'hFF, 1'b1, 2'd0, 1'b1}));
        repeat (3) @(negedge clk_32f);
        #1 reset_L = 1'b0;
        #1 chk("rst_async", 32'(obs()), 32'({4'b0000, 1'b0, 8'hBC, 1'b0, 2'd0, 1'b0}));
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b1111;
        in0 = 8'hAA;
        @(negedge clk_32f);
        chk("rst_held", 32'(obs()), 32'({4'b0000, 1'b0, 8'hBC, 1'b0, 2'd0, 1'b0}));
        @(negedge clk_32f);
        #1 reset_L = 1'b1;
        run_sync();
        @(negedge clk_32f);
        chk("resync_first_grant", 32'(obs()), 32'({4'b0001, 1'b0, 8'hBC, 1'b0, 2'd0, 1'b1}));
        @(negedge clk_32f);
        chk("resync_first_data", 32'(obs()), 32'({4'b0000, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b1}));

`ifdef PHY_SCHED_STATS_EN
        @(negedge clk_32f);
        #1 reset_L = 1'b0;
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b1000;
        repeat (2) @(negedge clk_32f);
        #1 reset_L = 1'b1;
        run_sync();
        repeat (10 * 8) @(negedge clk_32f);
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
        repeat (5 * 8) @(negedge clk_32f);
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'd0);
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'd0);
        chk("gnt_cnt2", 32'(gnt_cnt2), 32'd0);
        chk("gnt_cnt3", 32'(gnt_cnt3), 32'd10);
        chk("idle_cnt", 32'(idle_cnt), 32'd5);
        chk("sat_gnt_cnt3", 32'(s_gnt3), 32'd3);
        chk("sat_gnt_cnt0", 32'(s_gnt0), 32'd0);
        chk("sat_idle_cnt", 32'(s_idle), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
